// File: rtl/comp_pkg.sv
// Shared widths and types for the register file and its busy-bit scoreboard.
package comp_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned CNT_W      = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set when an issue reserves a destination, cleared by its writeback.
module reg_scoreboard #(
    parameter int unsigned NREGS = comp_pkg::NREGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      iss_valid,
    input  comp_pkg::reg_addr_t       iss_rd,
    input  logic                      wb_valid,
    input  comp_pkg::reg_addr_t       wb_rd,
    output logic                      iss_ready_c,
    output logic [NREGS-1:0]          busy
);
    import comp_pkg::*;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_hit;
    logic             iss_fire;

    // A writeback to the same register frees it this cycle, so a new issue may reserve it again.
    always_comb begin
        wb_hit      = wb_valid && (wb_rd != '0);
        iss_ready_c = (iss_rd == '0) || !busy_q[iss_rd] || (wb_valid && (wb_rd == iss_rd));
        iss_fire    = iss_valid && iss_ready_c && (iss_rd != '0);
        busy_d      = busy_q;
        if (wb_hit) begin
            busy_d[wb_rd] = 1'b0;
        end
        // Issue is applied last so a same-cycle issue and writeback leave the bit set.
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/reg_writeback.sv
// Register file with two combinational read ports, writeback port, busy tracking and write counter.
// Optional same-cycle writeback forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module reg_writeback #(
    parameter int unsigned XLEN  = comp_pkg::XLEN,
    parameter int unsigned NREGS = comp_pkg::NREGS
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  comp_pkg::reg_addr_t         rs1_addr,
    output logic [XLEN-1:0]             rs1_data,
    input  comp_pkg::reg_addr_t         rs2_addr,
    output logic [XLEN-1:0]             rs2_data,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    input  logic                        iss_valid,
    input  comp_pkg::reg_addr_t         iss_rd,
    output logic                        iss_ready,
    input  logic                        wb_valid,
    input  comp_pkg::reg_addr_t         wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    output logic                        wb_err,
    output logic [comp_pkg::CNT_W-1:0]  wr_count
);
    import comp_pkg::*;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy;
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic             wb_err_q;
    logic             wb_err_d;
    logic             wb_hit;

    reg_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk         (sys_clk),
        .rst_n       (sys_rst),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .iss_ready_c (iss_ready),
        .busy        (busy)
    );

    // Commit path: writes to x0 are dropped and never counted.
    always_comb begin
        wb_hit     = wb_valid && (wb_rd != '0);
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        wb_err_d   = wb_hit && !busy[wb_rd];
        if (wb_hit) begin
            regs_d[wb_rd] = wb_data;
            wr_count_d    = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // Read ports; x0 is hard-wired to zero and never busy.
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs1_busy = (rs1_addr != '0) && busy[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
        rs2_busy = (rs2_addr != '0) && busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
        end
        if (wb_hit && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
        end
`endif
    end

    assign wb_err   = wb_err_q;
    assign wr_count = wr_count_q;
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, the register data width.
REQ-002 SHALL have parameter NREGS, default 32, the register count; the address width is 5 bits.
REQ-003 SHALL have port sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rs1_addr  input  5  read port 1 address.
REQ-006 SHALL have port rs1_data  output  XLEN  read port 1 data.
REQ-007 SHALL have port rs2_addr  input  5  read port 2 address.
REQ-008 SHALL have port rs2_data  output  XLEN  read port 2 data.
REQ-009 SHALL have port rs1_busy / rs2_busy  output  1 each  the addressed register has a pending write.
REQ-010 SHALL have port iss_valid  input  1  an instruction reserving destination iss_rd is offered.
REQ-011 SHALL have port iss_rd  input  5  destination register of the issue.
REQ-012 SHALL have port iss_ready  output  1  the issue is accepted this cycle.
REQ-013 SHALL have port wb_valid  input  1  a writeback is presented; always accepted.
REQ-014 SHALL have port wb_rd / wb_data  input  5 / XLEN  writeback destination and value.
REQ-015 SHALL have port wb_err  output  1  one-cycle pulse on writeback to a non-reserved register.
REQ-016 SHALL have port wr_count  output  16  number of committed register writes.

Function
REQ-017 Reads SHALL be combinational; address 0 SHALL always read 0 with busy 0.
REQ-018 wb_valid with wb_rd != 0 SHALL write wb_data at the next edge; wb_rd == 0 SHALL be discarded and not counted.
REQ-019 Each register SHALL have a busy bit: set on an accepted issue (iss_valid & iss_ready & iss_rd != 0) and cleared on a writeback to that register.
REQ-020 iss_ready SHALL be !busy[iss_rd] | (wb_valid & wb_rd == iss_rd); iss_rd == 0 SHALL always be ready.
REQ-021 An issue and a writeback to the same register in the same cycle SHALL leave the busy bit at 1, with the data written.
REQ-022 wb_err SHALL pulse for exactly the next cycle when wb_valid, wb_rd != 0 and busy[wb_rd] == 0; the write SHALL still occur.
REQ-023 wr_count SHALL increment by 1 per committed write and wrap from 0xFFFF to 0x0000.
REQ-024 Writes SHALL be visible on the read ports in the cycle after the edge that commits them (without REGFILE_BYPASS_EN).

Reset
REQ-025 sys_rst low SHALL immediately clear all registers, all busy bits, wr_count and wb_err to 0, including mid-operation.
REQ-026 Issues and writebacks presented while sys_rst is low SHALL be ignored.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined: a read of address A != 0 while wb_valid & wb_rd == A SHALL return wb_data and report busy 0 in the same cycle.
REQ-028 Without REGFILE_BYPASS_EN: reads SHALL return the stored value and the current busy bit; there is no forwarding logic.

Structure
REQ-029 A shared package comp_pkg SHALL hold XLEN, REG_ADDR_W (5), NREGS and the reg_addr_t and word_t typedefs.
REQ-030 Busy-bit tracking SHALL be a sub-module reg_scoreboard; storage, forwarding and the counter stay in reg_writeback.

Verification
REQ-031 Reset, then wb x5 = 0x1234 without issue -> wb_err pulses 1 cycle; rs1_addr=5 reads 0x1234 next cycle; wr_count = 1.
REQ-032 Issue rd=3 -> rs1_busy=1 for addr 3; second issue rd=3 -> iss_ready=0; wb x3 = 0xAA -> busy clears, no wb_err.
REQ-033 Issue rd=7 and wb x7 = 0x55 in the same cycle (x7 previously reserved) -> iss_ready=1; x7 = 0x55; busy[7] stays 1.
REQ-034 wb x0 = 0xFFFFFFFF -> x0 reads 0; wr_count unchanged; REGFILE_BYPASS_EN build: wb x9 = 0x77 with rs2_addr=9 -> rs2_data=0x77 and rs2_busy=0 in the same cycle.
REQ-035 Preload wr_count = 0xFFFF via 65535 writes, then one more write -> wr_count = 0; assert sys_rst mid-burst -> all outputs 0 asynchronously.
